// File: rtl/mod_counter_ctrl.sv
// Command-driven sequencer for a programmable mod-N up-counter.
// Supports free-running or wrap-limited runs and reports tc, done and err pulses.
module mod_counter_ctrl #(
  parameter int WIDTH          = 2,
  parameter int DEFAULT_MOD_M1 = 3,
  parameter int WRAP_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [WRAP_W-1:0] cmd_arg,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SET   = 2'b11;

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    count_reg, count_next;
  logic [WIDTH-1:0]    mod_m1_reg, mod_m1_next;
  logic [WRAP_W-1:0]   wraps_reg, wraps_next;
  logic                limit_reg, limit_next;
  logic                tc_reg, tc_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;
  logic                accept;
  logic                advance;
  logic [WIDTH-1:0]    arg_mod;

  assign cmd_ready = (state_reg != DONE);
  assign accept    = cmd_valid && cmd_ready;
  assign arg_mod   = cmd_arg[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      mod_m1_reg <= WIDTH'(DEFAULT_MOD_M1);
      wraps_reg  <= '0;
      limit_reg  <= 1'b0;
      tc_reg     <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      mod_m1_reg <= mod_m1_next;
      wraps_reg  <= wraps_next;
      limit_reg  <= limit_next;
      tc_reg     <= tc_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    mod_m1_next = mod_m1_reg;
    wraps_next  = wraps_reg;
    limit_next  = limit_reg;
    tc_next     = 1'b0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    advance     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_START: begin
              state_next = RUN;
              count_next = '0;
              wraps_next = cmd_arg;
              limit_next = (cmd_arg != '0);
            end
            OP_CLEAR: count_next = '0;
            OP_SET: begin
              mod_m1_next = arg_mod;
              // Keep count inside the new range so the wrap compare still hits.
              if (count_reg > arg_mod) count_next = '0;
            end
            default: ;
          endcase
        end
      end

      RUN: begin
        // A rejected SET_MOD must not stall the count, so it still advances.
        advance = !accept || (cmd_op == OP_SET);
        if (accept) begin
          case (cmd_op)
            OP_START: begin
              count_next = '0;
              wraps_next = cmd_arg;
              limit_next = (cmd_arg != '0);
            end
            OP_STOP:  state_next = IDLE;
            OP_CLEAR: count_next = '0;
            default:  err_next   = 1'b1;
          endcase
        end
        if (advance) begin
          if (count_reg == mod_m1_reg) begin
            count_next = '0;
            tc_next    = 1'b1;
            if (limit_reg) begin
              wraps_next = wraps_reg - WRAP_W'(1);
              if (wraps_reg == WRAP_W'(1)) begin
                state_next = DONE;
                done_next  = 1'b1;
              end
            end
          end else begin
            count_next = count_reg + WIDTH'(1);
          end
        end
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign done  = done_reg;
  assign err   = err_reg;
  assign busy  = (state_reg == RUN);

endmodule
